// File: rtl/rename_map_table_pkg.sv
// Shared types and default sizing for the rename map table and its checkpoint store.
package tboom_rename_pkg;

   localparam int DATA_WIDTH       = 5;
   localparam int MEMORY_WIDTH     = 32;
   localparam int NUM_ARCH_REGS    = 1 << DATA_WIDTH;
   localparam int CHECKPOINT_DEPTH = 8;
   localparam int CKPT_POS_WIDTH   = $clog2(CHECKPOINT_DEPTH);

   // One physical register index per architectural register, entry 0 in the low bits.
   typedef logic [NUM_ARCH_REGS-1:0][DATA_WIDTH-1:0] map_t;

endpackage

// File: rtl/rename_map_table_if.sv
// Lookup, allocation-write and checkpoint/restore signals of the 2-wide rename map table.
interface rename_map_table_if #(
   parameter int DATA_WIDTH       = 5,
   parameter int MEMORY_WIDTH     = 32,
   parameter int CHECKPOINT_DEPTH = 8
);
   localparam int POS_WIDTH = $clog2(CHECKPOINT_DEPTH);

   logic                    checkpoint;
   logic                    restore;
   logic [POS_WIDTH-1:0]    checkpoint_restore_pos;

   logic                    i0_valid;
   logic                    i0_rd_valid;
   logic                    i0_rs1_valid;
   logic                    i0_rs2_valid;
   logic [DATA_WIDTH-1:0]   i0_arch_rs1;
   logic [DATA_WIDTH-1:0]   i0_arch_rs2;
   logic [DATA_WIDTH-1:0]   i0_arch_rd;

   logic                    i1_valid;
   logic                    i1_rd_valid;
   logic                    i1_rs1_valid;
   logic                    i1_rs2_valid;
   logic [DATA_WIDTH-1:0]   i1_arch_rs1;
   logic [DATA_WIDTH-1:0]   i1_arch_rs2;
   logic [DATA_WIDTH-1:0]   i1_arch_rd;

   logic                    write0_enable;
   logic [MEMORY_WIDTH-1:0] write0_pos;
   logic [DATA_WIDTH-1:0]   write0_phys_reg;
   logic                    write1_enable;
   logic [MEMORY_WIDTH-1:0] write1_pos;
   logic [DATA_WIDTH-1:0]   write1_phys_reg;

   logic                    i0_freelist_request;
   logic [DATA_WIDTH-1:0]   i0_phys_rs1;
   logic [DATA_WIDTH-1:0]   i0_phys_rs2;
   logic [DATA_WIDTH-1:0]   i0_phys_stale;
   logic                    i1_freelist_request;
   logic [DATA_WIDTH-1:0]   i1_phys_rs1;
   logic [DATA_WIDTH-1:0]   i1_phys_rs2;
   logic [DATA_WIDTH-1:0]   i1_phys_stale;

   modport master (
      output checkpoint, restore, checkpoint_restore_pos,
      output i0_valid, i0_rd_valid, i0_rs1_valid, i0_rs2_valid,
      output i0_arch_rs1, i0_arch_rs2, i0_arch_rd,
      output i1_valid, i1_rd_valid, i1_rs1_valid, i1_rs2_valid,
      output i1_arch_rs1, i1_arch_rs2, i1_arch_rd,
      output write0_enable, write0_pos, write0_phys_reg,
      output write1_enable, write1_pos, write1_phys_reg,
      input  i0_freelist_request, i0_phys_rs1, i0_phys_rs2, i0_phys_stale,
      input  i1_freelist_request, i1_phys_rs1, i1_phys_rs2, i1_phys_stale
   );

   modport slave (
      input  checkpoint, restore, checkpoint_restore_pos,
      input  i0_valid, i0_rd_valid, i0_rs1_valid, i0_rs2_valid,
      input  i0_arch_rs1, i0_arch_rs2, i0_arch_rd,
      input  i1_valid, i1_rd_valid, i1_rs1_valid, i1_rs2_valid,
      input  i1_arch_rs1, i1_arch_rs2, i1_arch_rd,
      input  write0_enable, write0_pos, write0_phys_reg,
      input  write1_enable, write1_pos, write1_phys_reg,
      output i0_freelist_request, i0_phys_rs1, i0_phys_rs2, i0_phys_stale,
      output i1_freelist_request, i1_phys_rs1, i1_phys_rs2, i1_phys_stale
   );

endinterface

// File: rtl/rename_map_table_ckpt.sv
// Snapshot storage: CHECKPOINT_DEPTH full copies of the map table, one full-table
// write port and one combinational full-table read port, reset to the identity map.
module rename_checkpoint_store
   import tboom_rename_pkg::*;
#(
   parameter int DATA_WIDTH       = tboom_rename_pkg::DATA_WIDTH,
   parameter int CHECKPOINT_DEPTH = tboom_rename_pkg::CHECKPOINT_DEPTH
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic                                          we,
   input  logic [$clog2(CHECKPOINT_DEPTH)-1:0]           waddr,
   input  logic [(1<<DATA_WIDTH)-1:0][DATA_WIDTH-1:0]    wdata,
   input  logic [$clog2(CHECKPOINT_DEPTH)-1:0]           raddr,
   output logic [(1<<DATA_WIDTH)-1:0][DATA_WIDTH-1:0]    rdata
);
   localparam int NREGS = 1 << DATA_WIDTH;

   logic [NREGS-1:0][DATA_WIDTH-1:0] slots [CHECKPOINT_DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < CHECKPOINT_DEPTH; s++) begin
            for (int i = 0; i < NREGS; i++) begin
               slots[s][i] <= DATA_WIDTH'(i);
            end
         end
      end else if (we) begin
         slots[waddr] <= wdata;
      end
   end

   // Read is combinational so a restore and a checkpoint to the same slot swap contents.
   assign rdata = slots[raddr];

endmodule

// File: rtl/rename_map_table.sv
// Speculative 2-wide register rename map table with full-table checkpoint/restore.
// Lookups read the registered map; writes, checkpoints and restores land at the edge.
module rename_map_table
   import tboom_rename_pkg::*;
#(
   parameter int DATA_WIDTH       = tboom_rename_pkg::DATA_WIDTH,
   parameter int MEMORY_WIDTH     = tboom_rename_pkg::MEMORY_WIDTH,
   parameter int CHECKPOINT_DEPTH = tboom_rename_pkg::CHECKPOINT_DEPTH
) (
   input logic              clk,
   input logic              rst,
   rename_map_table_if.slave bus
);
   localparam int NREGS = 1 << DATA_WIDTH;

   logic [NREGS-1:0][DATA_WIDTH-1:0] map;
   logic [NREGS-1:0][DATA_WIDTH-1:0] ckpt_rdata;
   logic [DATA_WIDTH-1:0]            w0_idx;
   logic [DATA_WIDTH-1:0]            w1_idx;
   logic                             w0_live;
   logic                             w1_live;
   logic                             unused_pos_bits;

   function automatic logic [DATA_WIDTH-1:0] lookup(
      input logic                             en,
      input logic [DATA_WIDTH-1:0]            idx,
      input logic [NREGS-1:0][DATA_WIDTH-1:0] tbl
   );
      return en ? tbl[idx] : '0;
   endfunction

   function automatic logic needs_alloc(
      input logic                  valid,
      input logic                  rd_valid,
      input logic [DATA_WIDTH-1:0] rd
   );
      return valid & rd_valid & (rd != '0);
   endfunction

   // Only the low DATA_WIDTH bits of the write position address the table.
   assign w0_idx          = bus.write0_pos[DATA_WIDTH-1:0];
   assign w1_idx          = bus.write1_pos[DATA_WIDTH-1:0];
   assign unused_pos_bits = ^{bus.write0_pos[MEMORY_WIDTH-1:DATA_WIDTH],
                              bus.write1_pos[MEMORY_WIDTH-1:DATA_WIDTH]};

   // x0 is never renamed, so index-0 writes are dropped and map[0] stays 0.
   assign w0_live = bus.write0_enable & (w0_idx != '0);
   assign w1_live = bus.write1_enable & (w1_idx != '0);

   rename_checkpoint_store #(
      .DATA_WIDTH       (DATA_WIDTH),
      .CHECKPOINT_DEPTH (CHECKPOINT_DEPTH)
   ) u_ckpt (
      .clk   (clk),
      .rst   (rst),
      .we    (bus.checkpoint),
      .waddr (bus.checkpoint_restore_pos),
      .wdata (map),
      .raddr (bus.checkpoint_restore_pos),
      .rdata (ckpt_rdata)
   );

   // Restore overrides both write ports; write1 is applied last so it wins on a collision.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            map[i] <= DATA_WIDTH'(i);
         end
      end else if (bus.restore) begin
         map <= ckpt_rdata;
      end else begin
         if (w0_live) map[w0_idx] <= bus.write0_phys_reg;
         if (w1_live) map[w1_idx] <= bus.write1_phys_reg;
      end
   end

   assign bus.i0_phys_rs1   = lookup(bus.i0_valid & bus.i0_rs1_valid, bus.i0_arch_rs1, map);
   assign bus.i0_phys_rs2   = lookup(bus.i0_valid & bus.i0_rs2_valid, bus.i0_arch_rs2, map);
   assign bus.i0_phys_stale = lookup(bus.i0_valid & bus.i0_rd_valid,  bus.i0_arch_rd,  map);
   assign bus.i1_phys_rs1   = lookup(bus.i1_valid & bus.i1_rs1_valid, bus.i1_arch_rs1, map);
   assign bus.i1_phys_rs2   = lookup(bus.i1_valid & bus.i1_rs2_valid, bus.i1_arch_rs2, map);
   assign bus.i1_phys_stale = lookup(bus.i1_valid & bus.i1_rd_valid,  bus.i1_arch_rd,  map);

   assign bus.i0_freelist_request = needs_alloc(bus.i0_valid, bus.i0_rd_valid, bus.i0_arch_rd);
   assign bus.i1_freelist_request = needs_alloc(bus.i1_valid, bus.i1_rd_valid, bus.i1_arch_rd);

endmodule

// File: tb/tb_rename_map_table.sv
// Randomized and directed bench for rename_map_table against an array-based reference model.
module tb_rename_map_table;
   import tboom_rename_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rename_map_table_if bus ();

   rename_map_table dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   int m_map  [32];
   int m_ckpt [8][32];

   string nm [8] = '{"i0_rs1", "i0_rs2", "i0_stale", "i0_req",
                     "i1_rs1", "i1_rs2", "i1_stale", "i1_req"};

   // Reference: a restore copies a snapshot, otherwise writes apply in port order,
   // and a checkpoint always saves the table as it stood before this edge.
   task automatic model_tick();
      int old [32];
      int cp, p0, p1;
      if (rst) begin
         for (int i = 0; i < 32; i++) m_map[i] = i;
         for (int s = 0; s < 8; s++)
            for (int i = 0; i < 32; i++) m_ckpt[s][i] = i;
      end else begin
         old = m_map;
         cp  = int'(bus.checkpoint_restore_pos);
         if (bus.restore) begin
            m_map = m_ckpt[cp];
         end else begin
            p0 = int'(bus.write0_pos % 32);
            p1 = int'(bus.write1_pos % 32);
            if (bus.write0_enable && p0 != 0) m_map[p0] = int'(bus.write0_phys_reg);
            if (bus.write1_enable && p1 != 0) m_map[p1] = int'(bus.write1_phys_reg);
         end
         if (bus.checkpoint) m_ckpt[cp] = old;
      end
   endtask

   task automatic tick();
      model_tick();
      @(posedge clk);
      #1;
   endtask

   task automatic snap(output logic [31:0] o [8]);
      o[0] = 32'(bus.i0_phys_rs1);
      o[1] = 32'(bus.i0_phys_rs2);
      o[2] = 32'(bus.i0_phys_stale);
      o[3] = 32'(bus.i0_freelist_request);
      o[4] = 32'(bus.i1_phys_rs1);
      o[5] = 32'(bus.i1_phys_rs2);
      o[6] = 32'(bus.i1_phys_stale);
      o[7] = 32'(bus.i1_freelist_request);
   endtask

   task automatic idle();
      bus.checkpoint = 1'b0; bus.restore = 1'b0; bus.checkpoint_restore_pos = '0;
      bus.i0_valid = 1'b0; bus.i0_rd_valid = 1'b0; bus.i0_rs1_valid = 1'b0; bus.i0_rs2_valid = 1'b0;
      bus.i0_arch_rs1 = '0; bus.i0_arch_rs2 = '0; bus.i0_arch_rd = '0;
      bus.i1_valid = 1'b0; bus.i1_rd_valid = 1'b0; bus.i1_rs1_valid = 1'b0; bus.i1_rs2_valid = 1'b0;
      bus.i1_arch_rs1 = '0; bus.i1_arch_rs2 = '0; bus.i1_arch_rd = '0;
      bus.write0_enable = 1'b0; bus.write0_pos = '0; bus.write0_phys_reg = '0;
      bus.write1_enable = 1'b0; bus.write1_pos = '0; bus.write1_phys_reg = '0;
   endtask

   task automatic set_slot(input int n, input bit v, input bit r1v, input bit r2v, input bit rdv,
                           input int rs1, input int rs2, input int rd);
      if (n == 0) begin
         bus.i0_valid = v; bus.i0_rs1_valid = r1v; bus.i0_rs2_valid = r2v; bus.i0_rd_valid = rdv;
         bus.i0_arch_rs1 = 5'(rs1); bus.i0_arch_rs2 = 5'(rs2); bus.i0_arch_rd = 5'(rd);
      end else begin
         bus.i1_valid = v; bus.i1_rs1_valid = r1v; bus.i1_rs2_valid = r2v; bus.i1_rd_valid = rdv;
         bus.i1_arch_rs1 = 5'(rs1); bus.i1_arch_rs2 = 5'(rs2); bus.i1_arch_rd = 5'(rd);
      end
   endtask

   task automatic test_reset();
      logic [31:0] g [8];
      int e [8];
      rst = 1'b1;
      idle();
      set_slot(0, 1, 1, 1, 1, 5, 9, 0);
      set_slot(1, 1, 1, 0, 1, 31, 0, 7);
      tick();
      snap(g);
      e = '{5, 9, 0, 0, 31, 0, 7, 1};
      for (int k = 0; k < 8; k++) begin
         n_checks++;
         if (g[k] !== 32'(e[k])) $display("FAIL reset_%s got %0d exp %0d", nm[k], g[k], e[k]);
         else n_pass++;
      end
      rst = 1'b0;
   endtask

   task automatic test_lookup();
      logic [31:0] g [8];
      int e [8];
      idle();
      set_slot(0, 1, 1, 1, 1, 1, 2, 3);
      set_slot(1, 1, 1, 1, 1, 4, 5, 6);
      #1;
      snap(g);
      e = '{1, 2, 3, 1, 4, 5, 6, 1};
      for (int k = 0; k < 8; k++) begin
         n_checks++;
         if (g[k] !== 32'(e[k])) $display("FAIL lookup_%s got %0d exp %0d", nm[k], g[k], e[k]);
         else n_pass++;
      end
   endtask

   task automatic test_write_pair();
      logic [31:0] g [8];
      int e [8];
      idle();
      set_slot(0, 1, 1, 1, 0, 1, 2, 0);
      bus.write0_enable = 1'b1; bus.write0_pos = 32'd1; bus.write0_phys_reg = 5'd31;
      bus.write1_enable = 1'b1; bus.write1_pos = 32'd2; bus.write1_phys_reg = 5'd30;
      #1;
      snap(g);
      e = '{1, 2, 0, 0, 0, 0, 0, 0};
      for (int k = 0; k < 8; k++) begin
         n_checks++;
         if (g[k] !== 32'(e[k])) $display("FAIL nobypass_%s got %0d exp %0d", nm[k], g[k], e[k]);
         else n_pass++;
      end
      tick();
      bus.write0_enable = 1'b0; bus.write1_enable = 1'b0;
      #1;
      snap(g);
      e = '{31, 30, 0, 0, 0, 0, 0, 0};
      for (int k = 0; k < 8; k++) begin
         n_checks++;
         if (g[k] !== 32'(e[k])) $display("FAIL wrpair_%s got %0d exp %0d", nm[k], g[k], e[k]);
         else n_pass++;
      end
   endtask

   task automatic test_invalid();
      logic [31:0] g [8];
      int e [8];
      idle();
      set_slot(0, 0, 1, 1, 1, 1, 2, 3);
      set_slot(1, 0, 1, 1, 1, 4, 5, 6);
      #1;
      snap(g);
      for (int k = 0; k < 8; k++) begin
         n_checks++;
         if (g[k] !== 32'd0) $display("FAIL invalid_%s got %0d exp 0", nm[k], g[k]);
         else n_pass++;
      end
      set_slot(0, 1, 0, 0, 1, 0, 0, 0);
      set_slot(1, 1, 1, 1, 0, 7, 1, 6);
      #1;
      snap(g);
      e = '{0, 0, 0, 0, 7, 31, 0, 0};
      for (int k = 0; k < 8; k++) begin
         n_checks++;
         if (g[k] !== 32'(e[k])) $display("FAIL rdzero_%s got %0d exp %0d", nm[k], g[k], e[k]);
         else n_pass++;
      end
   endtask

   task automatic test_checkpoint_restore();
      idle();
      bus.checkpoint = 1'b1; bus.checkpoint_restore_pos = 3'd3;
      tick();
      bus.checkpoint = 1'b0;
      bus.write0_enable = 1'b1; bus.write0_pos = 32'd1; bus.write0_phys_reg = 5'd15;
      tick();
      bus.write0_enable = 1'b0;
      set_slot(0, 1, 1, 0, 0, 1, 0, 0);
      #1;
      n_checks++;
      if (bus.i0_phys_rs1 !== 5'd15) $display("FAIL ckpt_after_write got %0d exp 15", bus.i0_phys_rs1);
      else n_pass++;
      bus.restore = 1'b1; bus.checkpoint_restore_pos = 3'd3;
      tick();
      bus.restore = 1'b0;
      #1;
      n_checks++;
      if (bus.i0_phys_rs1 !== 5'd31) $display("FAIL restore_slot3 got %0d exp 31", bus.i0_phys_rs1);
      else n_pass++;
   endtask

   task automatic test_same_index();
      idle();
      bus.write0_enable = 1'b1; bus.write0_pos = 32'd7; bus.write0_phys_reg = 5'd10;
      bus.write1_enable = 1'b1; bus.write1_pos = 32'd7; bus.write1_phys_reg = 5'd11;
      tick();
      bus.write0_enable = 1'b0; bus.write1_enable = 1'b0;
      set_slot(0, 1, 1, 1, 0, 7, 0, 0);
      #1;
      n_checks++;
      if (bus.i0_phys_rs1 !== 5'd11) $display("FAIL collide_w1_wins got %0d exp 11", bus.i0_phys_rs1);
      else n_pass++;
      // Position 0x20 maps to x0 and is dropped; 0xFFFFFFE9 maps to x9.
      bus.write0_enable = 1'b1; bus.write0_pos = 32'h0000_0020; bus.write0_phys_reg = 5'd20;
      bus.write1_enable = 1'b1; bus.write1_pos = 32'hFFFF_FFE9; bus.write1_phys_reg = 5'd22;
      tick();
      bus.write0_enable = 1'b0; bus.write1_enable = 1'b0;
      set_slot(0, 1, 1, 1, 0, 0, 9, 0);
      #1;
      n_checks++;
      if (bus.i0_phys_rs1 !== 5'd0) $display("FAIL x0_write_ignored got %0d exp 0", bus.i0_phys_rs1);
      else n_pass++;
      n_checks++;
      if (bus.i0_phys_rs2 !== 5'd22) $display("FAIL pos_high_bits got %0d exp 22", bus.i0_phys_rs2);
      else n_pass++;
   endtask

   task automatic test_restore_priority();
      idle();
      bus.restore = 1'b1; bus.checkpoint_restore_pos = 3'd3;
      bus.write0_enable = 1'b1; bus.write0_pos = 32'd1; bus.write0_phys_reg = 5'd5;
      bus.write1_enable = 1'b1; bus.write1_pos = 32'd2; bus.write1_phys_reg = 5'd3;
      tick();
      idle();
      set_slot(0, 1, 1, 1, 0, 1, 2, 0);
      #1;
      n_checks++;
      if (bus.i0_phys_rs1 !== 5'd31) $display("FAIL restore_over_w0 got %0d exp 31", bus.i0_phys_rs1);
      else n_pass++;
      n_checks++;
      if (bus.i0_phys_rs2 !== 5'd30) $display("FAIL restore_over_w1 got %0d exp 30", bus.i0_phys_rs2);
      else n_pass++;
   endtask

   task automatic test_ckpt_restore_same_slot();
      idle();
      bus.write0_enable = 1'b1; bus.write0_pos = 32'd4; bus.write0_phys_reg = 5'd17;
      tick();
      idle();
      bus.checkpoint = 1'b1; bus.restore = 1'b1; bus.checkpoint_restore_pos = 3'd5;
      tick();
      idle();
      set_slot(0, 1, 1, 1, 0, 4, 1, 0);
      #1;
      n_checks++;
      if (bus.i0_phys_rs1 !== 5'd4) $display("FAIL swap_map_old4 got %0d exp 4", bus.i0_phys_rs1);
      else n_pass++;
      n_checks++;
      if (bus.i0_phys_rs2 !== 5'd1) $display("FAIL swap_map_old1 got %0d exp 1", bus.i0_phys_rs2);
      else n_pass++;
      bus.restore = 1'b1; bus.checkpoint_restore_pos = 3'd5;
      tick();
      bus.restore = 1'b0;
      #1;
      n_checks++;
      if (bus.i0_phys_rs1 !== 5'd17) $display("FAIL swap_slot_new4 got %0d exp 17", bus.i0_phys_rs1);
      else n_pass++;
      n_checks++;
      if (bus.i0_phys_rs2 !== 5'd31) $display("FAIL swap_slot_new1 got %0d exp 31", bus.i0_phys_rs2);
      else n_pass++;
   endtask

   task automatic test_random(input int cycles);
      logic [31:0] g [8];
      int e [8];
      for (int c = 0; c < cycles; c++) begin
         set_slot(0, 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
         set_slot(1, 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
         bus.write0_enable = 1'($urandom); bus.write0_pos = $urandom; bus.write0_phys_reg = 5'($urandom);
         bus.write1_enable = 1'($urandom); bus.write1_pos = $urandom_range(0, 40);
         bus.write1_phys_reg = 5'($urandom);
         bus.checkpoint = ($urandom_range(0, 7) == 0);
         bus.restore    = ($urandom_range(0, 7) == 0);
         bus.checkpoint_restore_pos = 3'($urandom);
         #1;
         snap(g);
         e[0] = (bus.i0_valid && bus.i0_rs1_valid) ? m_map[bus.i0_arch_rs1] : 0;
         e[1] = (bus.i0_valid && bus.i0_rs2_valid) ? m_map[bus.i0_arch_rs2] : 0;
         e[2] = (bus.i0_valid && bus.i0_rd_valid)  ? m_map[bus.i0_arch_rd]  : 0;
         e[3] = (bus.i0_valid && bus.i0_rd_valid && bus.i0_arch_rd != 0) ? 1 : 0;
         e[4] = (bus.i1_valid && bus.i1_rs1_valid) ? m_map[bus.i1_arch_rs1] : 0;
         e[5] = (bus.i1_valid && bus.i1_rs2_valid) ? m_map[bus.i1_arch_rs2] : 0;
         e[6] = (bus.i1_valid && bus.i1_rd_valid)  ? m_map[bus.i1_arch_rd]  : 0;
         e[7] = (bus.i1_valid && bus.i1_rd_valid && bus.i1_arch_rd != 0) ? 1 : 0;
         for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (g[k] !== 32'(e[k])) $display("FAIL rand_c%0d_%s got %0d exp %0d", c, nm[k], g[k], e[k]);
            else n_pass++;
         end
         tick();
      end
   endtask

   task automatic test_mid_reset();
      idle();
      bus.write0_enable = 1'b1; bus.write0_pos = 32'd12; bus.write0_phys_reg = 5'd3;
      bus.checkpoint = 1'b1; bus.checkpoint_restore_pos = 3'd6;
      tick();
      rst = 1'b1;
      bus.write0_phys_reg = 5'd9;
      tick();
      rst = 1'b0;
      idle();
      bus.restore = 1'b1; bus.checkpoint_restore_pos = 3'd6;
      tick();
      idle();
      set_slot(0, 1, 1, 1, 1, 12, 2, 1);
      #1;
      n_checks++;
      if (bus.i0_phys_rs1 !== 5'd12) $display("FAIL midrst_map12 got %0d exp 12", bus.i0_phys_rs1);
      else n_pass++;
      n_checks++;
      if (bus.i0_phys_rs2 !== 5'(m_map[2])) $display("FAIL midrst_map2 got %0d exp %0d", bus.i0_phys_rs2, m_map[2]);
      else n_pass++;
      n_checks++;
      if (bus.i0_phys_stale !== 5'd1) $display("FAIL midrst_stale1 got %0d exp 1", bus.i0_phys_stale);
      else n_pass++;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      test_reset();
      test_lookup();
      test_write_pair();
      test_invalid();
      test_checkpoint_restore();
      test_same_index();
      test_restore_priority();
      test_ckpt_restore_same_slot();
      test_random(400);
      test_mid_reset();
      test_random(100);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/rename_map_table.md
# rename_map_table

Speculative register rename map table for a 2-wide RISC-V rename stage. It holds one physical-register mapping per architectural register. Per cycle it serves source and stale-destination lookups for two instruction slots and accepts two mapping writes from the freelist allocation path. It keeps `CHECKPOINT_DEPTH` full-table snapshots for branch-misprediction recovery.

## Interface
- `DATA_WIDTH`, 5: architectural and physical register index width. The table has 2^DATA_WIDTH entries.
- `MEMORY_WIDTH`, 32: width of the write position ports. Only bits [DATA_WIDTH-1:0] are used.
- `CHECKPOINT_DEPTH`, 8: number of snapshot slots. Must be a power of two, ≥2.
- `clk` in 1: single clock. All state updates on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `checkpoint` in 1: snapshot the table into slot `checkpoint_restore_pos`.
- `restore` in 1: reload the table from slot `checkpoint_restore_pos`.
- `checkpoint_restore_pos` in $clog2(CHECKPOINT_DEPTH): slot index for checkpoint and restore.
- `iN_valid` in 1 (N=0,1): slot N carries an instruction.
- `iN_rd_valid`, `iN_rs1_valid`, `iN_rs2_valid` in 1: the respective operand exists.
- `iN_arch_rs1`, `iN_arch_rs2`, `iN_arch_rd` in DATA_WIDTH: architectural indices.
- `writeN_enable` in 1: update the mapping.
- `writeN_pos` in MEMORY_WIDTH: architectural register to remap.
- `writeN_phys_reg` in DATA_WIDTH: new physical register.
- `iN_freelist_request` out 1: slot N needs a new physical register.
- `iN_phys_rs1`, `iN_phys_rs2` out DATA_WIDTH: current mapping of the sources.
- `iN_phys_stale` out DATA_WIDTH: current (to-be-freed) mapping of rd.

## Operation
- State:
  - `map[2^DATA_WIDTH]` of DATA_WIDTH bits.
  - `ckpt[CHECKPOINT_DEPTH][2^DATA_WIDTH]` of DATA_WIDTH bits.
- Reset:
  - `map[i] = i`.
  - Every `ckpt[s][i] = i`.
- Lookups are combinational from `map` as registered at the start of the cycle:
  - `iN_phys_rs1 = (iN_valid & iN_rs1_valid) ? map[iN_arch_rs1] : 0`. Same form for rs2.
  - `iN_phys_stale = (iN_valid & iN_rd_valid) ? map[iN_arch_rd] : 0`.
- `iN_freelist_request = iN_valid & iN_rd_valid & (iN_arch_rd != 0)`.
- Writes:
  - `writeN_enable` sets `map[writeN_pos[DATA_WIDTH-1:0]] <= writeN_phys_reg` at the edge.
  - Writes with pos index 0 are ignored, so `map[0]` always reads 0 (x0 is never renamed).
  - Both writes to the same index: write1 wins.
- No intra-bundle bypass. Slot 1 lookups do not see slot 0's rd, and same-cycle writes are not visible until the next cycle. Dependency forwarding belongs to the surrounding rename logic.
- `checkpoint`: `ckpt[pos] <= map`, the pre-write contents of the current cycle.
- `restore`: `map <= ckpt[pos]`. Overrides both write ports in the same cycle.
- `checkpoint` and `restore` together: restore loads the old slot content, and checkpoint stores the current `map`. Both take effect.
- Slots are addressed directly, with no pointer or wrap logic. Restoring a never-written slot yields the identity map.

## Timing
- Lookup and freelist_request latency: 0 cycles, combinational.
- Write, checkpoint and restore effect: visible on outputs the cycle after the edge that samples them.
- Reset has priority over everything. Asserting `rst` mid-operation discards all mappings and snapshots at that edge.
- All outputs during and right after reset: 0 unless valid inputs select identity-map entries.
- No handshake. Inputs are sampled every cycle, with no stall or backpressure.

## Structure
- Shared package `tboom_rename_pkg`: `DATA_WIDTH`, `NUM_ARCH_REGS`, `CHECKPOINT_DEPTH`, and `map_t` (the table array typedef).
- Sub-module `rename_checkpoint_store`: CHECKPOINT_DEPTH × map_t register array, with one full-table write port and one full-table read port.
- Top contains `map`, the write/restore priority mux, and six combinational read muxes.

## Test plan
- Reset, then slot 0 rs1=1, rs2=2, rd=3 and slot 1 rs1=4, rs2=5, rd=6, all valid → phys outputs 1, 2, 4, 5; stale 3 and 6; both freelist_request=1.
- write0 pos=1 phys=31 and write1 pos=2 phys=30 in one cycle → next cycle i0 rs1=1/rs2=2 read 31 and 30.
- i0_valid=i1_valid=0 → both freelist_request=0 and all phys outputs 0. Also rd=0 with valid → freelist_request=0.
- Checkpoint to slot 3 with map[1]=31. Then write pos=1 phys=15 (reads 15). Then restore slot 3 → i0 rs1=1 reads 31.
- Same-cycle write0 and write1 to pos 7 (phys 10, 11) → reads 11. A write to pos 0 → map[0] stays 0.
- Restore together with write0 to pos 1 → restored value wins. Checkpoint and restore to the same slot → map takes the old snapshot, and the slot holds the prior map.
